alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester n has an ALU operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester n operation accepted this cycle.
REQ-006 req0_op_a, req0_op_b / req1_op_a, req1_op_b  input  XLEN each  operands.
REQ-007 req0_ctrl / req1_ctrl  input  4 each  ALU op code (0000 ADD … 1000 SRA).
REQ-008 alu_op_a, alu_op_b  output  XLEN  operands to the shared alu.
REQ-009 alu_ctrl  output  4  op code to the shared alu.
REQ-010 alu_result  input  XLEN; alu_zero, alu_overflow  input  1  combinational alu outputs.
REQ-011 rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts.
REQ-012 rsp_id  output  1  index of requester that issued the op.
REQ-013 rsp_result  output  XLEN; rsp_zero, rsp_overflow, rsp_err  output  1  captured results.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; one op in flight at a time.
REQ-015 IDLE: if any req_valid, grant exactly one, assert its req_ready that cycle (combinational), latch op_a/op_b/ctrl/id, go EXEC; else stay.
REQ-016 req_ready SHALL be low in EXEC and RESP, and low for the non-granted requester.
REQ-017 Both valid in IDLE: round-robin; grant the requester not granted last; after reset req0 has priority.
REQ-018 Priority pointer updates only on response handshake (RESP and rsp_ready).
REQ-019 EXEC: alu_op_a/op_b/ctrl driven from latches; at next edge capture alu_result/zero/overflow into rsp registers, go RESP.
REQ-020 alu_* outputs SHALL always reflect the latched registers (stable outside grant edges).
REQ-021 Illegal ctrl (1001–1111): still sequenced; rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_err=1; alu_ctrl driven 0000.
REQ-022 RESP: rsp_valid=1, rsp_* stable until rsp_ready; on rsp_valid & rsp_ready go IDLE.
REQ-023 Latency: grant edge → rsp_valid high 2 cycles later; max throughput one op per 3 cycles with rsp_ready held high.
REQ-024 Requesters hold valid and operands until ready; withdrawn valid before grant is legal and not granted.
REQ-025 rsp_valid low in IDLE and EXEC; rsp_err low for legal codes.

Reset
REQ-026 rst_n low: state=IDLE, pointer=req1-last (req0 favoured), all latches and rsp_* = 0, rsp_valid=0, req_ready=0.
REQ-027 Reset mid-operation abandons the op; no response issued; requester must re-present.

Structure
REQ-028 Shared package alu_pkg holds ALU op-code constants (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA), ALU_CTRL_W=4, and the arbiter state type.
REQ-029 One sub-module rr_arb2: 2-way round-robin grant with pointer update input; alu itself stays external.

Verification
REQ-030 Single req0 ADD 5+3 → req0_ready one cycle, rsp_valid 2 cycles later, rsp_result=8, rsp_id=0, zero=0.
REQ-031 Both valid from reset: req0 SUB 5-3, req1 XOR FF00FF00^0F0F0F0F → responses id0 result 2, then id1 F00FF00F; third simultaneous round grants req1 first? no: grants req0 (alternation).
REQ-032 req1 ADD 7FFFFFFF+1 → rsp_result=80000000, rsp_overflow=1, rsp_id=1.
REQ-033 rsp_ready low 5 cycles in RESP → rsp_* stable, both req_ready low, no new grant; release → IDLE.
REQ-034 req0 ctrl=1111 → rsp_err=1, rsp_result=0, alu_ctrl=0000 during EXEC.
REQ-035 rst_n pulsed low during EXEC → all outputs 0 immediately, no response after release.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU arbiter. Holds the ALU op-code
//               constants, the op-code width, the arbiter state type and a
//               helper that classifies an op code as legal or illegal.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'b1000;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Op codes are dense from ADD up to SRA; anything above SRA is illegal.
  function automatic logic alu_ctrl_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl <= ALU_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant. When both requests are present
//               the requester that was not granted last wins. The "last
//               granted" pointer only moves when update is pulsed, so the
//               parent decides when a grant counts as completed.
// Ports       : clk, rst_n      clock, async active-low reset
//               req[1:0]        request vector (bit n = requester n)
//               update          move pointer this cycle
//               update_id       requester index to record as last granted
//               gnt[1:0]        one-hot (or zero) combinational grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_id,
  output logic [1:0] gnt
);

  // last_q = 1 means requester 1 was served last, so requester 0 is favoured.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update) begin
      last_d = update_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one external combinational ALU between two requesters.
//               One operation is in flight at a time: IDLE grants and latches
//               the operation, EXEC presents it to the ALU and captures the
//               result, RESP holds the response until the consumer accepts.
// Ports       : clk, rst_n                      clock, async active-low reset
//               reqN_valid/ready                requester N handshake
//               reqN_op_a/op_b/ctrl             requester N operation
//               alu_op_a/op_b/ctrl              to the shared ALU
//               alu_result/zero/overflow        from the shared ALU
//               rsp_valid/ready                 response handshake
//               rsp_id/result/zero/overflow/err captured response
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [XLEN-1:0]       req0_op_a,
  input  logic [XLEN-1:0]       req0_op_b,
  input  logic [ALU_CTRL_W-1:0] req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [XLEN-1:0]       req1_op_a,
  input  logic [XLEN-1:0]       req1_op_b,
  input  logic [ALU_CTRL_W-1:0] req1_ctrl,
  output logic [XLEN-1:0]       alu_op_a,
  output logic [XLEN-1:0]       alu_op_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [XLEN-1:0]       rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_err
);

  arb_state_e state_q, state_d;

  logic [XLEN-1:0]       op_a_q, op_a_d;
  logic [XLEN-1:0]       op_b_q, op_b_d;
  logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic                  id_q,   id_d;

  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_zero_q,   rsp_zero_d;
  logic            rsp_ovf_q,    rsp_ovf_d;
  logic            rsp_err_q,    rsp_err_d;
  logic            rsp_id_q,     rsp_id_d;

  logic [1:0] arb_gnt;
  logic [1:0] grant;
  logic       grant_en;
  logic       rsp_hs;
  logic       ctrl_legal;

  // Grants are only offered from IDLE. rst_n is folded in so that ready is
  // forced low while reset is held, even though state already reads IDLE.
  assign grant_en   = (state_q == ARB_IDLE) && rst_n;
  assign grant      = arb_gnt & {2{grant_en}};
  assign rsp_hs     = (state_q == ARB_RESP) && rsp_ready;
  assign ctrl_legal = alu_ctrl_legal(ctrl_q);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({req1_valid, req0_valid}),
    .update    (rsp_hs),
    .update_id (rsp_id_q),
    .gnt       (arb_gnt)
  );

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    ctrl_d       = ctrl_q;
    id_d         = id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant[1]) begin
          op_a_d  = req1_op_a;
          op_b_d  = req1_op_b;
          ctrl_d  = req1_ctrl;
          id_d    = 1'b1;
          state_d = ARB_EXEC;
        end else if (grant[0]) begin
          op_a_d  = req0_op_a;
          op_b_d  = req0_op_b;
          ctrl_d  = req0_ctrl;
          id_d    = 1'b0;
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        // Illegal op codes still take the full sequence but report an error
        // with a cleared result instead of whatever the ALU produced.
        rsp_result_d = ctrl_legal ? alu_result : '0;
        rsp_zero_d   = ctrl_legal & alu_zero;
        rsp_ovf_d    = ctrl_legal & alu_overflow;
        rsp_err_d    = ~ctrl_legal;
        rsp_id_d     = id_q;
        state_d      = ARB_RESP;
      end
      ARB_RESP: begin
        if (rsp_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      ctrl_q       <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      ctrl_q       <= ctrl_d;
      id_q         <= id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];

  // The ALU always sees the latched operation; illegal codes become ADD so
  // the external ALU never receives an undefined op code.
  assign alu_op_a     = op_a_q;
  assign alu_op_b     = op_b_q;
  assign alu_ctrl     = ctrl_legal ? ctrl_q : ALU_ADD;

  assign rsp_valid    = (state_q == ARB_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_err      = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Provides the external
//               ALU, drives directed and random operations from both
//               requesters and compares grants and responses against a
//               behavioural model of the arbitration and ALU rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ovf;
    logic            err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  rv [2];
  logic [XLEN-1:0]       ra [2];
  logic [XLEN-1:0]       rb [2];
  logic [ALU_CTRL_W-1:0] rc [2];

  logic                  req0_ready, req1_ready;
  logic [XLEN-1:0]       alu_op_a, alu_op_b, alu_result;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  alu_zero, alu_overflow;
  logic                  rsp_valid, rsp_ready, rsp_id;
  logic [XLEN-1:0]       rsp_result;
  logic                  rsp_zero, rsp_overflow, rsp_err;

  int n_assert = 0;
  int n_fail   = 0;
  int last_id  = 1;

  logic [XLEN-1:0] obs_result;
  logic            obs_id, obs_zero, obs_ovf, obs_err;

  // Plain-arithmetic ALU: used both as the external ALU and inside the model.
  function automatic rsp_t alu_fn(input logic [3:0] c, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
    rsp_t r;
    r = '0;
    case (c)
      4'd0: begin r.res = a + b; r.ovf = (a[31] == b[31]) && (r.res[31] != a[31]); end
      4'd1: begin r.res = a - b; r.ovf = (a[31] != b[31]) && (r.res[31] != a[31]); end
      4'd2: r.res = a & b;
      4'd3: r.res = a | b;
      4'd4: r.res = a ^ b;
      4'd5: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r.res = a << b[4:0];
      4'd7: r.res = a >> b[4:0];
      4'd8: r.res = $signed(a) >>> b[4:0];
      default: r.res = a + b;
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

  function automatic rsp_t ref_model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    rsp_t r;
    if (c > 4'd8) begin
      r = '0;
      r.err = 1'b1;
    end else begin
      r = alu_fn(c, a, b);
    end
    return r;
  endfunction

  rsp_t alu_r;
  assign alu_r        = alu_fn(alu_ctrl, alu_op_a, alu_op_b);
  assign alu_result   = alu_r.res;
  assign alu_zero     = alu_r.zero;
  assign alu_overflow = alu_r.ovf;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (rv[0]),
    .req0_ready   (req0_ready),
    .req0_op_a    (ra[0]),
    .req0_op_b    (rb[0]),
    .req0_ctrl    (rc[0]),
    .req1_valid   (rv[1]),
    .req1_ready   (req1_ready),
    .req1_op_a    (ra[1]),
    .req1_op_b    (rb[1]),
    .req1_ctrl    (rc[1]),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One complete operation. Entered just after a rising edge with the DUT
  // idle and at least one requester valid; returns just after the edge on
  // which the response is accepted.
  task automatic txn(input int hold);
    int              g;
    logic [XLEN-1:0] sa, sb;
    logic [3:0]      sc;
    rsp_t            e;
    if (rv[0] && rv[1]) g = 1 - last_id;
    else                g = rv[1] ? 1 : 0;
    sa = ra[g];
    sb = rb[g];
    sc = rc[g];
    e  = ref_model(sc, sa, sb);

    @(negedge clk);
    chk("grant", 32'({req1_ready, req0_ready}), (g == 1) ? 32'd2 : 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    @(posedge clk); #1;
    rv[g] = 1'b0;
    ra[g] = $urandom;
    rb[g] = $urandom;
    rc[g] = 4'($urandom_range(0, 8));

    @(negedge clk);
    chk("exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_alu_a", alu_op_a, sa);
    chk("exec_alu_b", alu_op_b, sb);
    chk("exec_alu_ctrl", 32'(alu_ctrl), (sc > 4'd8) ? 32'd0 : 32'(sc));

    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_flags", 32'({rsp_zero, rsp_overflow, rsp_err}), 32'({e.zero, e.ovf, e.err}));
    obs_result = rsp_result;
    obs_id     = rsp_id;
    obs_zero   = rsp_zero;
    obs_ovf    = rsp_overflow;
    obs_err    = rsp_err;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", rsp_result, e.res);
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_ready", 32'({req1_ready, req0_ready}), 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    last_id   = g;
  endtask

  task automatic set_req(input int r, input logic [3:0] c, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
    rv[r] = 1'b1;
    rc[r] = c;
    ra[r] = a;
    rb[r] = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      rv[r] = 1'b0; ra[r] = '0; rb[r] = '0; rc[r] = '0;
    end

    // Reset state, including ready held low while a requester is valid.
    #2;
    rv[0] = 1'b1;
    #1;
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_alu", alu_op_a | alu_op_b | 32'(alu_ctrl), 32'd0);
    rv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("idle_no_req_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Both valid from reset: req0 first, then req1, then alternation.
    set_req(0, ALU_SUB, 32'd5, 32'd3);
    set_req(1, ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    txn(0);
    chk("rr_first_id", 32'(obs_id), 32'd0);
    chk("rr_first_res", obs_result, 32'd2);
    txn(0);
    chk("rr_second_id", 32'(obs_id), 32'd1);
    chk("rr_second_res", obs_result, 32'hF00F_F00F);
    set_req(0, ALU_OR, 32'h1234_0000, 32'h0000_5678);
    set_req(1, ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
    txn(0);
    chk("rr_third_id", 32'(obs_id), 32'd0);
    txn(0);

    // Single req0 ADD 5+3.
    set_req(0, ALU_ADD, 32'd5, 32'd3);
    txn(0);
    chk("add_res", obs_result, 32'd8);
    chk("add_id_zero", 32'({obs_id, obs_zero}), 32'd0);

    // req1 signed overflow.
    set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    txn(0);
    chk("ovf_res", obs_result, 32'h8000_0000);
    chk("ovf_flag_id", 32'({obs_ovf, obs_id}), 32'd3);

    // Back-pressure for 5 cycles with the other requester waiting.
    set_req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    set_req(1, ALU_SRA, 32'h8000_0000, 32'd4);
    txn(5);
    txn(0);

    // Illegal op code.
    set_req(0, 4'hF, 32'd9, 32'd9);
    txn(0);
    chk("illegal_err_res", 32'({obs_err, 31'd0}) | obs_result, 32'h8000_0000);

    // Reset asserted during EXEC abandons the operation.
    set_req(0, ALU_ADD, 32'd100, 32'd23);
    @(negedge clk);
    chk("rst_op_grant", 32'({req1_ready, req0_ready}), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("midrst_alu", alu_op_a | alu_op_b | 32'(alu_ctrl), 32'd0);
    chk("midrst_rsp", rsp_result | 32'({rsp_valid, rsp_zero, rsp_overflow, rsp_err, rsp_id}), 32'd0);
    @(negedge clk);
    rv[0] = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    last_id = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    set_req(0, ALU_SLL, 32'd1, 32'd31);
    set_req(1, ALU_SRL, 32'h8000_0000, 32'd31);
    txn(0);
    chk("post_rst_prio", 32'(obs_id), 32'd0);
    txn(0);

    // Random traffic.
    for (int k = 0; k < 30; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rv[r] && ($urandom_range(0, 1) == 1)) begin
          set_req(r, 4'($urandom_range(0, 11)), rand_operand(), rand_operand());
          if ($urandom_range(0, 4) == 0) rb[r] = ra[r];
        end
      end
      if (!rv[0] && !rv[1]) begin
        set_req(0, 4'($urandom_range(0, 8)), rand_operand(), rand_operand());
      end
      txn(int'($urandom_range(0, 2)));
    end
    for (int d = 0; d < 2; d++) begin
      if (rv[0] || rv[1]) txn(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
